// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package fetch_unit_pkg;

    // Instruction presented to decode when the buffer is empty (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Default first fetch address after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order instruction buffer: registered storage, no bypass.
// A synchronous clear wins over push and pop in the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign do_push  = push && !full && !clear;
    assign do_pop   = pop && !empty && !clear;
    assign pop_data = mem_reg[rd_ptr_reg];
    assign count    = count_reg;

    // Pointer and occupancy bookkeeping; clear empties the buffer outright
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Entry storage; only the slot at the write pointer loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests under a
// credit limit, buffers in-order responses and hands {instr, pc, pc+4} to decode.
// Redirects flush the buffer and drop every response still in flight.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_pc_plus4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = 32 + DATA_WIDTH;

    fetch_state_e          state_reg, state_next;
    logic [DATA_WIDTH-1:0] pc_reg, pc_next;
    logic [CW-1:0]         outstanding_reg, outstanding_next;
    logic [CW-1:0]         discard_reg, discard_next;

    logic                  req_valid;
    logic                  accept;
    logic                  rsp_take;
    logic [CW:0]           credit_used;
    logic [DATA_WIDTH-1:0] rsp_pc;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [EW-1:0]         fifo_wdata, fifo_rdata;
    logic [31:0]           head_instr;
    logic [DATA_WIDTH-1:0] head_pc;
    logic                  unused_redirect_lsbs;

    // Low bits of the redirect target are dropped; instructions are word aligned
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Requests in flight plus buffered entries may never exceed the buffer depth,
    // which guarantees every response has a free slot when it arrives
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count};
    assign req_valid   = (state_reg == ST_FETCH) && !redirect_valid
                         && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign accept      = req_valid && imem_req_ready;

    // A response with nothing outstanding is stray and ignored
    assign rsp_take = imem_rsp_valid && (outstanding_reg != '0);

    // Responses return in order, so the oldest in-flight request sits 4*outstanding behind pc
    assign rsp_pc     = pc_reg - (DATA_WIDTH'(outstanding_reg) << 2);
    assign fifo_wdata = {imem_rsp_data, rsp_pc};
    assign fifo_push  = rsp_take && (discard_reg == '0) && !redirect_valid;
    assign fifo_pop   = out_valid && out_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_instr     = fifo_rdata[EW-1:DATA_WIDTH];
    assign head_pc        = fifo_rdata[DATA_WIDTH-1:0];
    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_reg;
    assign out_valid      = !fifo_empty;
    assign out_instr      = fifo_empty ? NOP_INSTR : head_instr;
    assign out_pc         = fifo_empty ? '0 : head_pc;
    assign out_pc_plus4   = fifo_empty ? '0 : head_pc + DATA_WIDTH'(4);

    // PC, in-flight count and stale-response count for the next cycle
    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg + CW'(accept) - CW'(rsp_take);
        discard_next     = discard_reg;
        if (redirect_valid) begin
            pc_next      = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            discard_next = outstanding_next;
        end else begin
            if (accept) pc_next = pc_reg + DATA_WIDTH'(4);
            if (rsp_take && (discard_reg != '0)) discard_next = discard_reg - CW'(1);
        end
    end

    // Next-state logic; a redirect overrides whatever the current state wants
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: state_next = ST_FETCH;
            ST_FLUSH: if (discard_next == '0) state_next = ST_FETCH;
            default:  state_next = ST_IDLE;
        endcase
        if (redirect_valid) begin
            state_next = (discard_next != '0) ? ST_FLUSH : ST_FETCH;
        end
    end

    // State register and fetch bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full));

    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (outstanding_reg == '0)));

endmodule
